// File: rtl/iq_frame_buffer.sv
// ============================================================================
// iq_frame_buffer
//   Collects synchronized I/Q samples into a two-bank frame buffer and
//   streams each completed frame out over a valid/ready handshake.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iq_frame_buffer #(
  parameter int DATA_W    = 9,
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] signal_in_real,
  input  logic [DATA_W-1:0] signal_in_imag,
  input  logic              done,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [7:0]        drop_count
);

  localparam logic [0:0] WR_FILL   = 1'b0;
  localparam logic [0:0] WR_WAIT   = 1'b1;
  localparam logic [0:0] RD_IDLE   = 1'b0;
  localparam logic [0:0] RD_STREAM = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] mem_real [0:2*FRAME_LEN-1];
  logic [DATA_W-1:0] mem_imag [0:2*FRAME_LEN-1];

  logic              done_meta;
  logic              done_sync;
  logic              done_prev;
  logic              cap;

  logic [0:0]        wr_state;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_idx;
  logic [0:0]        rd_state;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_idx;
  logic [1:0]        full;

  logic              store;
  logic              drop;
  logic              wr_done;
  logic              rd_hs;
  logic              rd_done;
  logic              other_free;

  // done is asynchronous to clk; two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      done_meta <= done;
      done_sync <= done_meta;
      done_prev <= done_sync;
    end
  end

  assign cap = done_sync & ~done_prev;

  always_comb begin
    store      = cap && (wr_state == WR_FILL);
    drop       = cap && (wr_state == WR_WAIT);
    wr_done    = store && (wr_idx == LAST_IDX);
    rd_hs      = out_valid && out_ready;
    rd_done    = rd_hs && (rd_idx == LAST_IDX);
    // a bank being released by the reader this very cycle counts as free
    other_free = !full[~wr_bank] || (rd_done && (rd_bank == ~wr_bank));
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_real[{wr_bank, wr_idx}] <= signal_in_real;
      mem_imag[{wr_bank, wr_idx}] <= signal_in_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (rd_done) full[rd_bank] <= 1'b0;
      if (wr_done) full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_FILL;
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
    end else begin
      case (wr_state)
        WR_FILL: begin
          if (store) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_done) begin
              if (other_free) wr_bank  <= ~wr_bank;
              else            wr_state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (!full[~wr_bank]) begin
            wr_state <= WR_FILL;
            wr_bank  <= ~wr_bank;
          end
        end
        default: wr_state <= WR_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Banks are always written alternately, so the oldest frame is simply the next bank in turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (full[rd_bank]) begin
            rd_state <= RD_STREAM;
            rd_idx   <= '0;
          end
        end
        RD_STREAM: begin
          if (rd_hs) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_done) begin
              rd_bank <= ~rd_bank;
              if (!full[~rd_bank]) rd_state <= RD_IDLE;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign out_valid = (rd_state == RD_STREAM);
  assign out_real  = out_valid ? mem_real[{rd_bank, rd_idx}] : '0;
  assign out_imag  = out_valid ? mem_imag[{rd_bank, rd_idx}] : '0;
  assign out_index = out_valid ? rd_idx : '0;
  assign out_last  = out_valid && (rd_idx == LAST_IDX);

endmodule

`default_nettype wire

// File: doc/iq_frame_buffer.md
Name: iq_frame_buffer

Overview:
- Downstream stage of the ADC sample converter: consumes its 9-bit signed I/Q pairs and `done` strobe.
- Assembles the samples into fixed-length frames in a ping-pong (two-bank) buffer.
- Streams each completed frame to the FFT/processing stage over a valid/ready handshake.
- The converter runs on the ADC `eoc` edge, so `done` is treated as asynchronous to `clk` and synchronized here.

Parameters:
- DATA_W, 9, width of each signed I/Q component.
- FRAME_LEN, 64, samples per frame; power of 2, minimum 4.
- ADDR_W, 6, log2(FRAME_LEN).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- signal_in_real  input  DATA_W  signed real sample from the converter.
- signal_in_imag  input  DATA_W  signed imag sample from the converter.
- done  input  1  converter sample-ready level, asynchronous to clk.
- out_real  output  DATA_W  signed real sample of the frame being streamed.
- out_imag  output  DATA_W  signed imag sample of the frame being streamed.
- out_index  output  ADDR_W  position of the current sample within its frame.
- out_valid  output  1  out_real/out_imag/out_index/out_last are valid.
- out_ready  input  1  consumer accepts the current sample.
- out_last  output  1  current sample is index FRAME_LEN-1.
- overflow  output  1  sticky: one or more samples were dropped.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.
- drop_count  output  8  saturating count of dropped samples.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, both banks empty, write bank 0 at index 0, read FSM IDLE;
  - synchronizer flops cleared; storage contents don't-care.
- Input capture:
  - `done` passes through a 2-flop synchronizer, then a rising-edge detect gives a 1-cycle `cap` pulse.
  - `cap` asserts on the 3rd clk edge after `done` rises.
  - Input contract: signal_in_* stable from `done` rise until `cap` + 1 cycle; `done` low for at least 2 clk cycles between samples.
  - I and Q are stored as-is; no width change or rescaling.
- Write FSM, states FILL and WAIT:
  - FILL, on `cap`: store the pair at [wr_bank][wr_idx], wr_idx += 1.
  - On the store with wr_idx == FRAME_LEN-1: mark wr_bank full, reset wr_idx to 0.
    - If the other bank is empty, wr_bank toggles and the FSM stays in FILL.
    - Otherwise go to WAIT.
  - WAIT: each `cap` is dropped; set overflow, drop_count += 1 (saturates at 255).
  - WAIT leaves to FILL (on the toggled bank, index 0) the cycle after the other bank becomes empty.
  - The first `cap` after that resumes writing; no partial frames are ever emitted.
- Read FSM, states IDLE and STREAM:
  - IDLE: when any bank is full (the oldest first; frames are emitted in capture order), latch rd_bank, set rd_idx = 0, go to STREAM.
  - out_valid rises the cycle after the bank's full flag sets.
  - STREAM:
    - out_valid = 1; out_real/out_imag come from [rd_bank][rd_idx]; out_index = rd_idx; out_last = (rd_idx == FRAME_LEN-1).
    - Outputs hold stable while out_valid && !out_ready.
    - Handshake = out_valid && out_ready; rd_idx += 1 per handshake.
    - Handshake on out_last: clear rd_bank's full flag. If the other bank is full, continue STREAM on it with no bubble; else go to IDLE with out_valid = 0 next cycle.
  - out_real/out_imag/out_index/out_last are 0 whenever out_valid = 0.
- Simultaneous events:
  - Write completes bank A on the same cycle the read frees bank B: wr_bank toggles to B; no overflow.
  - `cap` together with clear_overflow: the clear wins for overflow, and drop_count loads 1 if that `cap` was dropped.
  - out_ready may be held high continuously; throughput is 1 sample/cycle.
- Latency:
  - `done` rise to last-sample store: 3 cycles.
  - Frame complete to first out_valid: 1 cycle (read FSM idle).
- Reset mid-frame or mid-stream discards all buffered data immediately.

Test Plan:
- FRAME_LEN=4, 4 `done` pulses carrying real = -255, -1, 0, 255 (imag = 1, 2, 3, 4), out_ready = 1 -> out_valid on 4 consecutive cycles, out_index 0..3 with those values, out_last only on index 3, overflow = 0.
- out_ready toggling 1-0-1-0 during streaming -> data/index held during ready = 0 cycles; exactly 4 handshakes; frame cleared only after the out_last handshake.
- out_ready = 0, 12 samples -> banks 0 and 1 fill; last 4 samples dropped; overflow = 1, drop_count = 4. Then ready = 1 -> two frames emitted in capture order back-to-back, no bubble at the frame boundary.
- drop_count saturation: 300 dropped samples -> drop_count = 255. Pulse clear_overflow -> overflow = 0, drop_count = 0.
- `done` pulse 1 cycle wide or changing near a clk edge -> exactly one capture per rising edge, never two. Data captured equals the value present at `done` rise.
- rst_n asserted mid-stream at index 2 -> outputs go to 0 asynchronously. After release, a new frame starts at index 0; no stale samples are emitted.
